tap_tempo_detector: RTL and testbench

//  Inverse of the beat-rate divider: measures the interval between player taps on a push

---
 rtl/tempo_pkg.sv | 29 ++
 rtl/tap_conditioner.sv | 47 ++++
 rtl/tap_tempo_detector.sv | 115 +++++++++++
 tb/tb_tap_tempo_detector.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared tempo definitions: speed-code BPM table, state encoding and the
// threshold helper used by both the beat-rate divider and the tap detector.
package tempo_pkg;

    localparam int SPEED_W    = 3;
    localparam int NUM_SPEEDS = 8;

    localparam int unsigned BPM [NUM_SPEEDS] = '{40, 60, 80, 100, 120, 140, 180, 220};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_LOCK  = 2'd2
    } tap_state_e;

    // Interval (in clk cycles) halfway between the periods of codes k and k+1:
    // cyc*(1/b0 + 1/b1)/2 rewritten as one truncating integer division.
    function automatic logic [63:0] tempo_threshold(input logic [63:0] cyc_per_min,
                                                    input int          k);
        int          k_next;
        logic [63:0] lo;
        logic [63:0] hi;
        k_next = k + 1;
        lo     = 64'(BPM[k[2:0]]);
        hi     = 64'(BPM[k_next[2:0]]);
        return (cyc_per_min * (lo + hi)) / (64'd2 * lo * hi);
    endfunction

endpackage

// File: rtl/tap_conditioner.sv
// Button conditioner: 2-flop synchroniser, falling-edge detect and a lockout
// window that swallows contact bounce after each accepted press.
module tap_conditioner
    import tempo_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LOCK_W       = $clog2(DEBOUNCE_CYC + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_n_i,
    output logic tap_pulse_o
);

    logic [1:0]        sync_q;
    logic              prev_q;
    logic [1:0]        warm_q;
    logic              armed_q;
    logic [LOCK_W-1:0] lock_q;

    // Edges count only once a genuine released level has been seen, so a key
    // held through reset cannot masquerade as a fresh press.
    assign tap_pulse_o = armed_q && prev_q && !sync_q[1] && (lock_q == '0);

    // NOTE: sequential state is always assigned with <=, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
            lock_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            prev_q  <= sync_q[1];
            warm_q  <= {warm_q[0], 1'b1};
            armed_q <= armed_q | (warm_q[1] & sync_q[1]);
            if (tap_pulse_o) begin
                lock_q <= LOCK_W'(DEBOUNCE_CYC);
            end else if (lock_q != '0) begin
                lock_q <= lock_q - LOCK_W'(1);
            end
        end
    end

endmodule

// File: rtl/tap_tempo_detector.sv
// Tap-tempo detector: times the gap between conditioned taps, averages the
// last two gaps and quantises the estimate to the 3-bit divider speed code.
module tap_tempo_detector
    import tempo_pkg::*;
#(
    parameter logic [32:0] CYC_PER_MIN  = 33'd3_000_000_000,
    parameter int          CNT_W        = 27,
    parameter int          MIN_CYC      = 10_000_000,
    parameter int          TIMEOUT_CYC  = 100_000_000,
    parameter int          DEBOUNCE_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_n,
    output logic [SPEED_W-1:0] speed,
    output logic               speed_valid,
    output logic               locked,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);

    localparam logic [63:0] THR [NUM_SPEEDS-1] = '{
        tempo_threshold(64'(CYC_PER_MIN), 0),
        tempo_threshold(64'(CYC_PER_MIN), 1),
        tempo_threshold(64'(CYC_PER_MIN), 2),
        tempo_threshold(64'(CYC_PER_MIN), 3),
        tempo_threshold(64'(CYC_PER_MIN), 4),
        tempo_threshold(64'(CYC_PER_MIN), 5),
        tempo_threshold(64'(CYC_PER_MIN), 6)
    };

    // Longer intervals mean slower tempo; ties resolve to the slower code.
    function automatic logic [SPEED_W-1:0] quantise(input logic [CNT_W-1:0] est);
        logic [SPEED_W-1:0] code;
        code = SPEED_W'(NUM_SPEEDS - 1);
        for (int k = NUM_SPEEDS - 2; k >= 0; k--) begin
            if (64'(est) >= THR[k]) code = k[SPEED_W-1:0];
        end
        return code;
    endfunction

    tap_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   prev_q;
    logic [SPEED_W-1:0] speed_q;
    logic               speed_valid_q;
    logic               timeout_q;

    logic               tap_pulse;
    logic [CNT_W:0]     sum;
    logic [CNT_W-1:0]   est;

    tap_conditioner #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_cond (
        .clk         (clk),
        .resetn      (resetn),
        .key_n_i     (key_n),
        .tap_pulse_o (tap_pulse)
    );

    assign sum = {1'b0, prev_q} + {1'b0, cnt_q};
    assign est = (state_q == ST_LOCK) ? sum[CNT_W:1] : cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            prev_q        <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            speed_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            if (cnt_q < TIMEOUT_V) cnt_q <= cnt_q + CNT_W'(1);

            unique case (state_q)
                ST_IDLE: begin
                    if (tap_pulse) begin
                        state_q <= ST_FIRST;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_FIRST, ST_LOCK: begin
                    if (cnt_q == TIMEOUT_V) begin
                        // A coincident tap still opens a new sequence.
                        timeout_q <= 1'b1;
                        if (tap_pulse) begin
                            state_q <= ST_FIRST;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (tap_pulse && cnt_q >= MIN_V) begin
                        speed_q       <= quantise(est);
                        speed_valid_q <= 1'b1;
                        prev_q        <= cnt_q;
                        cnt_q         <= CNT_W'(1);
                        state_q       <= ST_LOCK;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign speed       = speed_q;
    assign speed_valid = speed_valid_q;
    assign timeout     = timeout_q;
    assign locked      = (state_q == ST_LOCK);

endmodule

// File: tb/tb_tap_tempo_detector.sv
// Directed bench for tap_tempo_detector with scaled-down timing constants
// (thresholds 1250,875,675,550,464,380,303 cycles).
module tb_tap_tempo_detector;

    localparam int HOLD = 20;

    logic       clk;
    logic       resetn;
    logic       key_n;
    logic [2:0] speed;
    logic       speed_valid;
    logic       locked;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int vcnt;
    int tcnt;
    int pcnt;
    int last_spd;

    tap_tempo_detector #(
        .CYC_PER_MIN  (33'd60000),
        .CNT_W        (27),
        .MIN_CYC      (200),
        .TIMEOUT_CYC  (2000),
        .DEBOUNCE_CYC (50)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_n       (key_n),
        .speed       (speed),
        .speed_valid (speed_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters, cleared while reset is held.
    always @(negedge clk) begin
        if (!resetn) begin
            vcnt     = 0;
            tcnt     = 0;
            pcnt     = 0;
            last_spd = 0;
        end else begin
            if (speed_valid) begin
                vcnt++;
                last_spd = int'(speed);
            end
            if (timeout)       tcnt++;
            if (dut.tap_pulse) pcnt++;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_n  = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Press lands `gap` cycles after the previous press started.
    task automatic tap(input int gap);
        repeat (gap - HOLD) @(negedge clk);
        key_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_n = 1'b1;
    endtask

    task automatic bounce_press();
        @(negedge clk);
        key_n = 1'b0;
        repeat (10) @(negedge clk);
        key_n = 1'b1;
        repeat (3) @(negedge clk);
        key_n = 1'b0;
        repeat (HOLD - 13) @(negedge clk);
        key_n = 1'b1;
    endtask

    initial begin
        key_n  = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_speed", int'(speed), 0);
        check("rst_valid", int'(speed_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_timeout", int'(timeout), 0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Steady 1000-cycle taps -> code 1 on every tap after the first.
        tap(100);
        settle();
        check("t1k_first_novalid", vcnt, 0);
        tap(1000);
        settle();
        check("t1k_second_valid", vcnt, 1);
        check("t1k_second_speed", last_spd, 1);
        check("t1k_second_locked", int'(locked), 1);
        tap(1000);
        tap(1000);
        settle();
        check("t1k_valid_count", vcnt, 3);
        check("t1k_speed", int'(speed), 1);
        check("t1k_locked", int'(locked), 1);

        // 500-cycle taps -> code 4.
        do_reset();
        tap(10); tap(500); tap(500); tap(500);
        settle();
        check("t500_valid_count", vcnt, 3);
        check("t500_speed", int'(speed), 4);

        // 1500 then 500 -> averaged 1000 -> code 1.
        do_reset();
        tap(10); tap(1500);
        settle();
        check("avg_first_valid", vcnt, 1);
        check("avg_first_speed", last_spd, 0);
        tap(500);
        settle();
        check("avg_second_speed", int'(speed), 1);

        // Threshold equality.
        do_reset();
        tap(10); tap(875);
        settle();
        check("thr_875", int'(speed), 1);
        do_reset();
        tap(10); tap(874);
        settle();
        check("thr_874", int'(speed), 2);

        // Bounce on the first press, early re-press ignored.
        do_reset();
        bounce_press();
        repeat (40) @(negedge clk);
        settle();
        check("bounce_one_tap", pcnt, 1);
        tap(150 - 41);
        settle();
        check("repress_tap_seen", pcnt, 2);
        check("repress_no_valid", vcnt, 0);
        tap(850);
        settle();
        check("bounce_valid", vcnt, 1);
        check("bounce_speed", int'(speed), 1);

        // Timeout after a lock, then restart.
        do_reset();
        tap(10); tap(1000);
        repeat (2100) @(negedge clk);
        settle();
        check("to_pulse_count", tcnt, 1);
        check("to_locked", int'(locked), 0);
        check("to_speed_held", int'(speed), 1);
        tap(500);
        settle();
        check("to_restart_novalid", vcnt, 1);
        tap(600);
        settle();
        check("to_new_valid", vcnt, 2);
        check("to_new_speed", int'(speed), 3);

        // Reset mid-LOCK with the key held across it.
        do_reset();
        tap(10); tap(1000);
        @(negedge clk);
        key_n = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_speed", int'(speed), 0);
        check("midrst_locked", int'(locked), 0);
        resetn = 1'b1;
        repeat (200) @(negedge clk);
        settle();
        check("held_no_tap", pcnt, 0);
        check("held_locked", int'(locked), 0);
        key_n = 1'b1;
        repeat (20) @(negedge clk);
        tap(HOLD + 10);
        settle();
        check("after_release_tap", pcnt, 1);
        tap(500);
        settle();
        check("after_release_speed", int'(speed), 4);
        check("after_release_valid", vcnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
